i2c_reg_master: RTL and testbench

I2C_REG_MASTER -- requirements
Module: i2c_reg_master

---
 rtl/flash_i2c_define.sv | 45 ++++
 rtl/i2c_quarter_tick.sv | 34 +++
 rtl/i2c_reg_master.sv | 175 +++++++++++++++++
 tb/tb_i2c_reg_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_i2c_define.sv
// flash_i2c_define -- shared definitions for the I2C register master.
//   - default prescaler and target address constants
//   - FSM state encoding
//   - busLevels(): open-drain drive pattern {scl_oe, sda_oe} for a
//     given state / quarter-phase / outgoing data bit
package flash_i2c_define;

  localparam int         DEFAULT_CLK_DIV  = 125;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h3C;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TX_BYTE,
    RX_ACK,
    RSTART,
    RX_BYTE,
    TX_NACK,
    STOP
  } i2cState_t;

  // Quarter numbering inside one bit slot: 0,1 = SCL low; 2,3 = SCL high.
  // Returns {sclOe, sdaOe}; a 1 pulls the line low.
  function automatic logic [1:0] busLevels(i2cState_t st, logic [1:0] q, logic txBit);
    logic [1:0] lv;
    lv = 2'b00;
    case (st)
      IDLE:    lv = 2'b00;
      // SCL stays high; SDA falls halfway through.
      START:   lv = {1'b0, q[1]};
      TX_BYTE: lv = {~q[1], ~txBit};
      RX_ACK,
      RX_BYTE,
      TX_NACK: lv = {~q[1], 1'b0};
      // Coming out of an ACK slot SCL is high: drop SCL once so SDA can be
      // released, raise SCL, then pull SDA low while SCL is high.
      RSTART:  lv = {(q == 2'd0), q[1]};
      // Hold SDA low across the SCL rise, then release SDA while SCL is high.
      STOP:    lv = {(q == 2'd0), ~q[1]};
      default: lv = 2'b00;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick -- CLK_DIV prescaler for the I2C bit timing.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   en    in  count enable; while low the prescaler is held at zero so the
//             first quarter after enabling is a full CLK_DIV cycles long
//   tick  out one-cycle pulse on the last clk cycle of every quarter-phase
module i2c_quarter_tick
  import flash_i2c_define::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] divCnt;

  assign tick = en && (divCnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt <= '0;
    end else if (!en || tick) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_reg_master.sv
// i2c_reg_master -- single-register I2C write/read master.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   start    in  one-cycle request, accepted only in IDLE
//   rw       in  0 = register write, 1 = register read (sampled with start)
//   reg_addr in  register address (sampled with start)
//   wdata    in  write data (sampled with start)
//   busy     out transaction in progress
//   done     out one-cycle completion pulse
//   ack_err  out a target ACK slot was read high (valid with done)
//   rdata    out last successfully read byte
//   scl_oe   out 1 = pull SCL low
//   sda_oe   out 1 = pull SDA low
//   sda_i    in  synchronised SDA line level
module i2c_reg_master
  import flash_i2c_define::*;
#(
  parameter int         CLK_DIV  = DEFAULT_CLK_DIV,
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  i2cState_t  state;
  logic [1:0] quarter;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic [1:0] byteIdx;     // 0 = address(W), 1 = register, 2 = data / address(R)
  logic       rwLat;
  logic [7:0] regAddrLat;
  logic [7:0] wdataLat;
  logic       ackBit;
  logic       readOk;
  logic       tick;
  logic       tickEn;

  assign tickEn = (state != IDLE);

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) uQuarterTick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tickEn),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      quarter    <= 2'd0;
      bitCnt     <= 3'd0;
      shiftReg   <= 8'h00;
      byteIdx    <= 2'd0;
      rwLat      <= 1'b0;
      regAddrLat <= 8'h00;
      wdataLat   <= 8'h00;
      ackBit     <= 1'b0;
      readOk     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
      rdata      <= 8'h00;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      done <= 1'b0;
      // Bus drive is a registered decode of the current phase; every quarter
      // is shifted uniformly by one clk, so quarter lengths are unaffected.
      {scl_oe, sda_oe} <= busLevels(state, quarter, shiftReg[7]);

      if (state == IDLE) begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done) begin
          rwLat      <= rw;
          regAddrLat <= reg_addr;
          wdataLat   <= wdata;
          ack_err    <= 1'b0;
          readOk     <= 1'b0;
          busy       <= 1'b1;
          quarter    <= 2'd0;
          bitCnt     <= 3'd0;
          byteIdx    <= 2'd0;
          state      <= START;
        end
      end else if (tick) begin
        quarter <= quarter + 2'd1;
        case (state)
          START: begin
            if (quarter == 2'd3) begin
              shiftReg <= {DEV_ADDR, 1'b0};
              state    <= TX_BYTE;
            end
          end
          TX_BYTE: begin
            if (quarter == 2'd3) begin
              shiftReg <= {shiftReg[6:0], 1'b0};
              bitCnt   <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) state <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (quarter == 2'd2) begin
              ackBit <= sda_i;
            end else if (quarter == 2'd3) begin
              if (ackBit) begin
                ack_err <= 1'b1;
                state   <= STOP;
              end else begin
                case (byteIdx)
                  2'd0: begin
                    byteIdx  <= 2'd1;
                    shiftReg <= regAddrLat;
                    state    <= TX_BYTE;
                  end
                  2'd1: begin
                    if (rwLat) begin
                      state <= RSTART;
                    end else begin
                      byteIdx  <= 2'd2;
                      shiftReg <= wdataLat;
                      state    <= TX_BYTE;
                    end
                  end
                  default: state <= rwLat ? RX_BYTE : STOP;
                endcase
              end
            end
          end
          RSTART: begin
            if (quarter == 2'd3) begin
              byteIdx  <= 2'd2;
              shiftReg <= {DEV_ADDR, 1'b1};
              state    <= TX_BYTE;
            end
          end
          RX_BYTE: begin
            if (quarter == 2'd2) begin
              shiftReg <= {shiftReg[6:0], sda_i};
            end else if (quarter == 2'd3) begin
              bitCnt <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                readOk <= 1'b1;
                state  <= TX_NACK;
              end
            end
          end
          TX_NACK: begin
            if (quarter == 2'd3) state <= STOP;
          end
          STOP: begin
            if (quarter == 2'd3) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (readOk) rdata <= shiftReg;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// tb_i2c_reg_master -- directed bench with an open-drain bus and a small
// I2C target model that logs bytes, ACKs/NACKs and serves one read byte.
module tb_i2c_reg_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, ack_err;
  logic [7:0] rdata;
  logic       scl_oe, sda_oe, sda_i;
  logic       slaveDrive = 1'b0;

  assign sda_i = ~(sda_oe | slaveDrive);

  always #5 clk = ~clk;

  i2c_reg_master #(.CLK_DIV(4), .DEV_ADDR(7'h3C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rw       (rw),
    .reg_addr (reg_addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .rdata    (rdata),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .sda_i    (sda_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Target model state
  int         bitPos = 0;
  int         nBytes = 0;
  int         startCount = 0;
  int         stopCount = 0;
  int         doneCount = 0;
  int         nackIdx = -1;
  int         cyc = 0;
  int         lastRise = -1;
  int         sclPeriod = -1;
  logic [7:0] byteLog [8];
  logic [7:0] byteBuf = 8'h00;
  logic [7:0] txShift = 8'h00;
  logic [7:0] readData = 8'h00;
  logic       inRead = 1'b0;
  logic       firstOfFrame = 1'b0;
  logic       addrRead = 1'b0;
  logic       ackSeen = 1'b0;
  logic       masterNack = 1'b0;
  logic       sclPrev = 1'b1;
  logic       sdaPrev = 1'b1;

  always @(negedge clk) begin
    logic lineScl, lineSda;
    lineScl = ~scl_oe;
    lineSda = sda_i;
    cyc++;
    if (done) doneCount++;
    if (!rst_n) begin
      slaveDrive = 1'b0;
      bitPos     = 0;
      inRead     = 1'b0;
      addrRead   = 1'b0;
    end else if (sclPrev && lineScl && sdaPrev && !lineSda) begin
      startCount++;
      bitPos       = 0;
      firstOfFrame = 1'b1;
      inRead       = 1'b0;
      addrRead     = 1'b0;
    end else if (sclPrev && lineScl && !sdaPrev && lineSda) begin
      stopCount++;
    end else if (!sclPrev && lineScl) begin
      if (lastRise >= 0 && sclPeriod < 0) sclPeriod = cyc - lastRise;
      lastRise = cyc;
      if (bitPos < 8) byteBuf = {byteBuf[6:0], lineSda};
      else ackSeen = lineSda;
      bitPos++;
    end else if (sclPrev && !lineScl) begin
      if (bitPos == 8) begin
        if (inRead) begin
          slaveDrive = 1'b0;
        end else begin
          if (nBytes < 8) byteLog[nBytes] = byteBuf;
          slaveDrive   = (nBytes != nackIdx);
          addrRead     = firstOfFrame && byteBuf[0];
          firstOfFrame = 1'b0;
          nBytes++;
        end
      end else if (bitPos == 9) begin
        bitPos     = 0;
        slaveDrive = 1'b0;
        if (inRead) begin
          masterNack = ackSeen;
          inRead     = 1'b0;
        end else if (addrRead && !ackSeen) begin
          inRead     = 1'b1;
          addrRead   = 1'b0;
          txShift    = readData;
          slaveDrive = ~txShift[7];
        end
      end else if (inRead && bitPos >= 1 && bitPos <= 7) begin
        slaveDrive = ~txShift[7 - bitPos];
      end
    end
    sclPrev = lineScl;
    sdaPrev = lineSda;
  end

  task automatic clearLog();
    nBytes     = 0;
    startCount = 0;
    stopCount  = 0;
    doneCount  = 0;
    nackIdx    = -1;
    masterNack = 1'b0;
    lastRise   = -1;
    sclPeriod  = -1;
  endtask

  task automatic doTxn(input string tag, input logic r, input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clk);
    rw = r; reg_addr = ra; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal({tag, " busy after start"}, busy, 1);
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, " done seen"}, done, 1);
    checkVal({tag, " busy low at done"}, busy, 0);
  endtask

  initial begin
    // Reset state
    #1;
    checkVal("rst busy", busy, 0);
    checkVal("rst done", done, 0);
    checkVal("rst ack_err", ack_err, 0);
    checkVal("rst rdata", rdata, 8'h00);
    checkVal("rst scl_oe", scl_oe, 0);
    checkVal("rst sda_oe", sda_oe, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Write 0xA5 to register 0x02
    clearLog();
    doTxn("wr", 1'b0, 8'h02, 8'hA5);
    waitDone("wr");
    checkVal("wr ack_err", ack_err, 0);
    checkVal("wr nbytes", nBytes, 3);
    checkVal("wr byte0", byteLog[0], 8'h78);
    checkVal("wr byte1", byteLog[1], 8'h02);
    checkVal("wr byte2", byteLog[2], 8'hA5);
    checkVal("wr starts", startCount, 1);
    // start raised in the same cycle as done must be dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("wr start-at-done ignored", busy, 0);
    repeat (10) @(negedge clk);
    checkVal("wr stops", stopCount, 1);
    checkVal("wr scl period", sclPeriod, 16);
    checkVal("wr done count", doneCount, 1);
    checkVal("wr bus released", {30'd0, scl_oe, sda_oe}, 0);

    // Read register 0x05, target returns 0x5A
    clearLog();
    readData = 8'h5A;
    doTxn("rd", 1'b1, 8'h05, 8'h00);
    waitDone("rd");
    checkVal("rd rdata", rdata, 8'h5A);
    checkVal("rd ack_err", ack_err, 0);
    checkVal("rd nbytes", nBytes, 3);
    checkVal("rd byte0", byteLog[0], 8'h78);
    checkVal("rd byte1", byteLog[1], 8'h05);
    checkVal("rd byte2", byteLog[2], 8'h79);
    repeat (10) @(negedge clk);
    checkVal("rd starts", startCount, 2);
    checkVal("rd stops", stopCount, 1);
    checkVal("rd master nack", masterNack, 1);

    // Target NACKs the address byte
    clearLog();
    nackIdx = 0;
    readData = 8'hC3;
    doTxn("nk", 1'b1, 8'h09, 8'h00);
    waitDone("nk");
    checkVal("nk ack_err", ack_err, 1);
    checkVal("nk rdata held", rdata, 8'h5A);
    repeat (10) @(negedge clk);
    checkVal("nk nbytes", nBytes, 1);
    checkVal("nk stops", stopCount, 1);

    // start pulsed mid-write is ignored
    clearLog();
    doTxn("mid", 1'b0, 8'h11, 8'h3C);
    checkVal("mid ack_err cleared", ack_err, 0);
    repeat (100) @(negedge clk);
    rw = 1'b1; reg_addr = 8'hEE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("mid");
    repeat (20) @(negedge clk);
    checkVal("mid nbytes", nBytes, 3);
    checkVal("mid byte0", byteLog[0], 8'h78);
    checkVal("mid byte1", byteLog[1], 8'h11);
    checkVal("mid byte2", byteLog[2], 8'h3C);
    checkVal("mid starts", startCount, 1);
    checkVal("mid done count", doneCount, 1);

    // Reset during the register-address byte
    clearLog();
    doTxn("rs", 1'b0, 8'h33, 8'h44);
    begin
      int n;
      n = 0;
      while (nBytes < 1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    checkVal("rs addr byte sent", nBytes, 1);
    repeat (40) @(negedge clk);
    checkVal("rs busy before reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkVal("rs scl_oe", scl_oe, 0);
    checkVal("rs sda_oe", sda_oe, 0);
    checkVal("rs busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    checkVal("rs no done", doneCount, 0);

    clearLog();
    doTxn("post", 1'b0, 8'h07, 8'h81);
    waitDone("post");
    checkVal("post ack_err", ack_err, 0);
    checkVal("post nbytes", nBytes, 3);
    checkVal("post byte0", byteLog[0], 8'h78);
    checkVal("post byte1", byteLog[1], 8'h07);
    checkVal("post byte2", byteLog[2], 8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
